qdma_master: RTL and testbench
==============================

QDMA_MASTER -- requirements
Module: qdma_master

Interface
REQ-001 Parameter NXM_TIMEOUT, default 200: qclk cycles (10 us at 20 MHz) to wait for RRPLY before declaring non-existent memory.
REQ-002 Parameter ASETUP, default 3: cycles DAL carries address before TSYNC (150 ns); AHOLD, default 2: cycles address holds after TSYNC (100 ns).
REQ-003 Parameter DSETUP, default 2: cycles write data precedes TDOUT; RDLY, default 3: cycles after synchronized RRPLY before read data is latched.
REQ-004 qclk  in  1  single system clock, 20 MHz, all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 req  in  1  DMA transfer request, sampled only in IDLE.
REQ-007 wr  in  1  1 = DATO (write), 0 = DATI (read); captured with req.
REQ-008 addr  in  22  QBUS byte address; captured with req.
REQ-009 wdata  in  16  write data; captured with req.
REQ-010 busy  out  1  high from acceptance until done.
REQ-011 done  out  1  one-cycle pulse at transfer end.
REQ-012 rdata  out  16  latched read data, valid with done when wr=0 and nxm=0.
REQ-013 nxm  out  1  valid with done; 1 = RRPLY timeout.
REQ-014 DALtx  out  1  DAL transceiver direction, 1 = FPGA drives.
REQ-015 DAL  inout  22  shared address/data lines; high-Z unless DALtx=1.
REQ-016 RDMGI, RSYNC, RRPLY  in  1 each  received bus signals, asserted high.
REQ-017 TDMR, TSACK, TSYNC, TDIN, TDOUT, TBS7, TWTBT, TDMGO  out  1 each  transmitted bus signals, asserted high.

Function
REQ-018 RDMGI, RSYNC, RRPLY pass through two-flop synchronizers before any FSM use.
REQ-019 States: IDLE, REQ, WAITBUS, ADDR, AHOLD, WDATA, DOUT, DIN, RDWAIT, END, RELEASE.
REQ-020 IDLE: req=1 captures wr/addr/wdata, sets busy -> REQ; TDMR asserted.
REQ-021 REQ: synchronized RDMGI=1 -> assert TSACK, negate TDMR -> WAITBUS.
REQ-022 TDMGO = raw RDMGI in IDLE; 0 in all other states (grant never passed while requesting or mastering).
REQ-023 WAITBUS: stay until synchronized RSYNC=0 and RRPLY=0 -> ADDR.
REQ-024 ADDR: DALtx=1, DAL=addr, TBS7=(addr[21:13]=all ones), TWTBT=wr, ASETUP cycles -> AHOLD with TSYNC=1.
REQ-025 AHOLD: keep address AHOLD cycles, then negate TBS7/TWTBT; wr=1 -> WDATA, wr=0 -> DIN with DALtx=0.
REQ-026 WDATA: DAL={6'b0,wdata} for DSETUP cycles -> DOUT with TDOUT=1, data held.
REQ-027 DIN: TDIN=1 until synchronized RRPLY=1 -> RDWAIT; after RDLY cycles latch DAL[15:0] into rdata -> END.
REQ-028 DOUT: TDOUT=1 until synchronized RRPLY=1 -> END.
REQ-029 NXM counter: clears on DIN/DOUT entry; reaching NXM_TIMEOUT without RRPLY sets nxm -> END, rdata unchanged.
REQ-030 END: negate TDIN/TDOUT; wait synchronized RRPLY=0 (or immediate if nxm) -> RELEASE; DALtx=0, TSYNC negated.
REQ-031 RELEASE: negate TSACK, pulse done, clear busy -> IDLE; new req accepted no earlier than next cycle.
REQ-032 req while busy ignored; capture registers unchanged until next IDLE acceptance.
REQ-033 Never assert TSYNC and TDMR in same cycle; TDIN and TDOUT mutually exclusive.

Reset
REQ-034 reset asynchronously forces IDLE; all T* outputs, DALtx, busy, done, nxm =0; rdata=0; counters and synchronizers =0.
REQ-035 reset mid-transfer releases bus within same cycle (DAL high-Z); no done pulse for aborted transfer.

Structure
REQ-036 Shared package qbus_pkg holds FSM state enum and default timing constants (ASETUP, AHOLD, DSETUP, RDLY, NXM_TIMEOUT).
REQ-037 One sub-module: qsync2, a two-flop synchronizer with async reset, instanced per received signal.

Verification
REQ-038 Bench instances qdrv, qsync, sreg_block at 'o440 and 'o560, grant arbiter returning RDMGI 200 ns after TDMR.
REQ-039 Read: req, wr=0, addr='o17760440 -> TBS7=1 during address, done, nxm=0, rdata='o123456.
REQ-040 Write/readback: write 'o054321 to 'o17760440, then read -> rdata='o054321, nxm=0 both.
REQ-041 NXM: read 'o17760400 -> done exactly NXM_TIMEOUT cycles after TDIN assertion, nxm=1, TSYNC/TSACK negated after.
REQ-042 Grant passthrough/bus busy: idle RDMGI=1 -> TDMGO=1; during REQ -> TDMGO=0; other master holding SYNC delays ADDR until release.
REQ-043 Reset asserted during DIN wait -> same cycle all T* and DALtx =0; next req completes normally with rdata='o123456.

Source files
------------

// File: rtl/qbus_pkg.sv
// Shared QBUS DMA master definitions: FSM state codes, default bus timing
// and the I/O-page decode helper.
package qbus_pkg;
    localparam int NXM_TIMEOUT_DEF = 200;
    localparam int ASETUP_DEF      = 3;
    localparam int AHOLD_DEF       = 2;
    localparam int DSETUP_DEF      = 2;
    localparam int RDLY_DEF        = 3;

    typedef logic [3:0] qstate_t;

    localparam qstate_t ST_IDLE    = 4'd0;
    localparam qstate_t ST_REQ     = 4'd1;
    localparam qstate_t ST_WAITBUS = 4'd2;
    localparam qstate_t ST_ADDR    = 4'd3;
    localparam qstate_t ST_AHOLD   = 4'd4;
    localparam qstate_t ST_WDATA   = 4'd5;
    localparam qstate_t ST_DOUT    = 4'd6;
    localparam qstate_t ST_DIN     = 4'd7;
    localparam qstate_t ST_RDWAIT  = 4'd8;
    localparam qstate_t ST_END     = 4'd9;
    localparam qstate_t ST_RELEASE = 4'd10;

    // BS7 marks the I/O page: the top nine address bits all ones.
    function automatic logic isIoPage(input logic [8:0] hi);
        return &hi;
    endfunction
endpackage

// File: rtl/qsync2.sv
// Two-flop synchronizer for one received QBUS signal.
module qsync2 (
    input  logic qclk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Two-stage capture into the qclk domain
    always_ff @(posedge qclk or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/qdma_master.sv
// QBUS DMA bus master: requests the bus, runs one DATI or DATO cycle with
// programmable setup/hold timing, and reports NXM on reply timeout.
module qdma_master
    import qbus_pkg::*;
#(
    parameter int NXM_TIMEOUT = NXM_TIMEOUT_DEF,
    parameter int ASETUP      = ASETUP_DEF,
    parameter int AHOLD       = AHOLD_DEF,
    parameter int DSETUP      = DSETUP_DEF,
    parameter int RDLY        = RDLY_DEF
) (
    input  logic        qclk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [21:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        nxm,
    output logic        DALtx,
    inout  wire  [21:0] DAL,
    input  logic        RDMGI,
    input  logic        RSYNC,
    input  logic        RRPLY,
    output logic        TDMR,
    output logic        TSACK,
    output logic        TSYNC,
    output logic        TDIN,
    output logic        TDOUT,
    output logic        TBS7,
    output logic        TWTBT,
    output logic        TDMGO
);
    localparam logic [15:0] ASETUP_LAST = 16'(ASETUP - 1);
    localparam logic [15:0] AHOLD_LAST  = 16'(AHOLD - 1);
    localparam logic [15:0] DSETUP_LAST = 16'(DSETUP - 1);
    localparam logic [15:0] RDLY_LAST   = 16'(RDLY - 1);
    // END and RELEASE use up the last two cycles of the reply budget
    localparam logic [15:0] NXM_LAST    = 16'(NXM_TIMEOUT - 2);

    qstate_t     state_r;
    qstate_t     stateNext_s;
    logic [15:0] cnt_r;
    logic [15:0] cntNext_s;
    logic        capWr_r;
    logic [21:0] capAddr_r;
    logic [15:0] capWdata_r;
    logic [21:0] dalOut_r;
    logic        accept_s;
    logic        nxmSet_s;
    logic        latch_s;
    logic        rdmgiS_s;
    logic        rsyncS_s;
    logic        rrplyS_s;

    qsync2 uSyncDmg  (.qclk(qclk), .reset(reset), .d(RDMGI), .q(rdmgiS_s));
    qsync2 uSyncSync (.qclk(qclk), .reset(reset), .d(RSYNC), .q(rsyncS_s));
    qsync2 uSyncRply (.qclk(qclk), .reset(reset), .d(RRPLY), .q(rrplyS_s));

    // Next-state decode; the phase counter restarts on every state change
    always_comb begin
        stateNext_s = state_r;
        cntNext_s   = 16'd0;
        accept_s    = 1'b0;
        nxmSet_s    = 1'b0;
        latch_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    stateNext_s = ST_REQ;
                    accept_s    = 1'b1;
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (rdmgiS_s) stateNext_s = ST_WAITBUS;
                else          stateNext_s = ST_REQ;
            end
            ST_WAITBUS: begin
                if (!rsyncS_s && !rrplyS_s) stateNext_s = ST_ADDR;
                else                        stateNext_s = ST_WAITBUS;
            end
            ST_ADDR: begin
                if (cnt_r == ASETUP_LAST) stateNext_s = ST_AHOLD;
                else                      stateNext_s = ST_ADDR;
            end
            ST_AHOLD: begin
                if (cnt_r == AHOLD_LAST) stateNext_s = capWr_r ? ST_WDATA : ST_DIN;
                else                     stateNext_s = ST_AHOLD;
            end
            ST_WDATA: begin
                if (cnt_r == DSETUP_LAST) stateNext_s = ST_DOUT;
                else                      stateNext_s = ST_WDATA;
            end
            ST_DOUT, ST_DIN: begin
                if (rrplyS_s) begin
                    stateNext_s = (state_r == ST_DIN) ? ST_RDWAIT : ST_END;
                end else if (cnt_r == NXM_LAST) begin
                    stateNext_s = ST_END;
                    nxmSet_s    = 1'b1;
                end else begin
                    stateNext_s = state_r;
                end
            end
            ST_RDWAIT: begin
                if (cnt_r == RDLY_LAST) begin
                    stateNext_s = ST_END;
                    latch_s     = 1'b1;
                end else begin
                    stateNext_s = ST_RDWAIT;
                end
            end
            ST_END: begin
                if (nxm || !rrplyS_s) stateNext_s = ST_RELEASE;
                else                  stateNext_s = ST_END;
            end
            ST_RELEASE: stateNext_s = ST_IDLE;
            default:    stateNext_s = ST_IDLE;
        endcase
        if (stateNext_s != state_r) cntNext_s = 16'd0;
        else                        cntNext_s = cnt_r + 16'd1;
    end

    // State and phase counter
    always_ff @(posedge qclk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= stateNext_s;
            cnt_r   <= cntNext_s;
        end
    end

    // Transfer capture, result flags and read-data latch
    always_ff @(posedge qclk or posedge reset) begin
        if (reset) begin
            capWr_r    <= 1'b0;
            capAddr_r  <= 22'd0;
            capWdata_r <= 16'd0;
            nxm        <= 1'b0;
            rdata      <= 16'd0;
        end else begin
            if (accept_s) begin
                capWr_r    <= wr;
                capAddr_r  <= addr;
                capWdata_r <= wdata;
                nxm        <= 1'b0;
            end
            if (nxmSet_s) nxm   <= 1'b1;
            if (latch_s)  rdata <= DAL[15:0];
        end
    end

    // Bus outputs registered from the next state so they line up with state_r
    always_ff @(posedge qclk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            TDMR     <= 1'b0;
            TSACK    <= 1'b0;
            TSYNC    <= 1'b0;
            TDIN     <= 1'b0;
            TDOUT    <= 1'b0;
            TBS7     <= 1'b0;
            TWTBT    <= 1'b0;
            DALtx    <= 1'b0;
            dalOut_r <= 22'd0;
        end else begin
            busy  <= (stateNext_s != ST_IDLE) && (stateNext_s != ST_RELEASE);
            done  <= (stateNext_s == ST_RELEASE);
            TDMR  <= (stateNext_s == ST_REQ);
            TSACK <= stateNext_s inside {ST_WAITBUS, ST_ADDR, ST_AHOLD, ST_WDATA,
                                         ST_DOUT, ST_DIN, ST_RDWAIT, ST_END};
            TSYNC <= stateNext_s inside {ST_AHOLD, ST_WDATA, ST_DOUT, ST_DIN,
                                         ST_RDWAIT, ST_END};
            TDIN  <= stateNext_s inside {ST_DIN, ST_RDWAIT};
            TDOUT <= (stateNext_s == ST_DOUT);
            TBS7  <= (stateNext_s inside {ST_ADDR, ST_AHOLD}) && isIoPage(capAddr_r[21:13]);
            TWTBT <= (stateNext_s inside {ST_ADDR, ST_AHOLD}) && capWr_r;
            DALtx <= (stateNext_s inside {ST_ADDR, ST_AHOLD}) ||
                     (capWr_r && (stateNext_s inside {ST_WDATA, ST_DOUT, ST_END}));
            dalOut_r <= (stateNext_s inside {ST_ADDR, ST_AHOLD}) ? capAddr_r
                                                                  : {6'd0, capWdata_r};
        end
    end

    assign DAL = DALtx ? dalOut_r : 22'bz;
    // Raw grant pass-through keeps the daisy chain free of synchronizer delay
    assign TDMGO = (state_r == ST_IDLE) & RDMGI;
endmodule

// File: tb/tb_qdma_master.sv
// Self-checking bench for qdma_master with a behavioural QBUS slave/arbiter
// and an abstract register-file reference model.
module tb_qdma_master;
    localparam int          NXM_T = 200;
    localparam logic [21:0] A440  = 22'o17760440;
    localparam logic [21:0] A560  = 22'o17760560;
    localparam logic [21:0] A400  = 22'o17760400;

    logic        qclk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [21:0] addr = 22'd0;
    logic [15:0] wdata = 16'd0;
    logic        busy, done, nxm, DALtx;
    logic [15:0] rdata;
    wire  [21:0] DAL;
    logic        RDMGI, RSYNC, RRPLY;
    logic        TDMR, TSACK, TSYNC, TDIN, TDOUT, TBS7, TWTBT, TDMGO;

    // Slave / arbiter state
    logic        grantForce = 1'b0, otherSync = 1'b0, arbGrant = 1'b0;
    logic        slvDrive = 1'b0, slvReply = 1'b0, syncPrev = 1'b0;
    logic [15:0] slvData = 16'd0, mem440 = 16'o123456, mem560 = 16'd0;
    logic [21:0] latchedAddr = 22'd0;
    int          arbCnt = 0, replyCnt = 0;

    // Reference model state
    logic [15:0] ref440 = 16'o123456, ref560 = 16'd0, modelRd = 16'd0;

    int errors = 0, checks = 0, viol = 0;

    qdma_master dut (
        .qclk(qclk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .nxm(nxm), .DALtx(DALtx), .DAL(DAL),
        .RDMGI(RDMGI), .RSYNC(RSYNC), .RRPLY(RRPLY), .TDMR(TDMR), .TSACK(TSACK),
        .TSYNC(TSYNC), .TDIN(TDIN), .TDOUT(TDOUT), .TBS7(TBS7), .TWTBT(TWTBT),
        .TDMGO(TDMGO)
    );

    always #25 qclk = ~qclk;

    assign DAL   = slvDrive ? {6'd0, slvData} : 22'bz;
    assign RDMGI = grantForce | arbGrant;
    assign RSYNC = otherSync;
    assign RRPLY = slvReply;

    // Arbiter and register-block slave, evaluated on the falling edge
    initial begin
        logic hit;
        forever begin
            @(negedge qclk);
            if (TDMR) begin
                if (arbCnt < 4) arbCnt++;
                arbGrant = (arbCnt >= 4);
            end else begin
                arbCnt   = 0;
                arbGrant = 1'b0;
            end
            if (TSYNC && !syncPrev) latchedAddr = DAL;
            syncPrev = TSYNC;
            hit = TSYNC && (latchedAddr == A440 || latchedAddr == A560);
            if (hit && TDIN) begin
                if (replyCnt < 2) replyCnt++;
                else begin
                    slvData  = (latchedAddr == A440) ? mem440 : mem560;
                    slvDrive = 1'b1;
                    slvReply = 1'b1;
                end
            end else if (hit && TDOUT) begin
                if (!slvReply) begin
                    if (latchedAddr == A440) mem440 = DAL[15:0];
                    else                     mem560 = DAL[15:0];
                    slvReply = 1'b1;
                end
            end else begin
                replyCnt = 0;
                slvDrive = 1'b0;
                slvReply = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'o%0o, want 'o%0o", name, act, exp);
        end
    endtask

    // Expected outcome of one transfer against a two-register bus
    function automatic void model(input logic w, input logic [21:0] a, input logic [15:0] d,
                                  output logic expNx, output logic [15:0] expRd);
        expNx = !(a == A440 || a == A560);
        if (!expNx && w) begin
            if (a == A440) ref440 = d;
            else           ref560 = d;
        end
        if (!expNx && !w) modelRd = (a == A440) ? ref440 : ref560;
        expRd = modelRd;
    endfunction

    task automatic doXfer(input logic w, input logic [21:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output logic nx, output int lat,
                          output logic tbs7Seen, output logic grantLeak,
                          output logic released, output logic timedOut);
        int tdinAt = -1;
        int doneAt = -1;
        @(negedge qclk);
        req = 1'b1; wr = w; addr = a; wdata = d;
        tbs7Seen = 1'b0; grantLeak = 1'b0; timedOut = 1'b1; released = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge qclk);
            // inputs scrambled and a stray request while busy must be ignored
            req   = (i == 3);
            wr    = 1'($urandom);
            addr  = 22'($urandom);
            wdata = 16'($urandom);
            if (TDIN && tdinAt < 0) tdinAt = i;
            if (TBS7 && TSYNC) tbs7Seen = 1'b1;
            if (busy && TDMGO) grantLeak = 1'b1;
            if ((TSYNC && TDMR) || (TDIN && TDOUT)) viol++;
            if (done) begin
                doneAt   = i;
                timedOut = 1'b0;
                released = !(TSYNC || TSACK || DALtx || busy);
                break;
            end
        end
        req = 1'b0;
        rd  = rdata;
        nx  = nxm;
        lat = (tdinAt < 0 || doneAt < 0) ? -1 : doneAt - tdinAt;
    endtask

    task automatic runCheck(input string name, input logic w, input logic [21:0] a,
                            input logic [15:0] d, input logic expNx,
                            input logic [15:0] expRd, input logic chkRd);
        logic [15:0] rd;
        logic        nx, tbs7Seen, grantLeak, released, timedOut;
        logic [8:0]  top;
        int          lat;
        doXfer(w, a, d, rd, nx, lat, tbs7Seen, grantLeak, released, timedOut);
        top = a[21:13];
        chk({name, "_timeout"}, 32'(timedOut), 32'd0);
        chk({name, "_nxm"}, 32'(nx), 32'(expNx));
        if (chkRd) chk({name, "_rdata"}, 32'(rd), 32'(expRd));
        chk({name, "_bs7"}, 32'(tbs7Seen), 32'(&top));
        chk({name, "_released"}, 32'(released), 32'd1);
        chk({name, "_tdmgo_busy"}, 32'(grantLeak), 32'd0);
        if (expNx && !w) chk({name, "_nxm_latency"}, 32'(lat), 32'(NXM_T));
    endtask

    typedef struct {
        logic        w;
        logic [21:0] a;
        logic [15:0] d;
        logic        expNx;
        logic [15:0] expRd;
        logic        chkRd;
    } vec_t;

    initial begin
        vec_t        vecs[8];
        logic        mNx, seen, busyBad, doneSeen;
        logic [15:0] mRd;

        vecs[0] = '{1'b0, A440, 16'o0,      1'b0, 16'o123456, 1'b1};
        vecs[1] = '{1'b1, A440, 16'o054321, 1'b0, 16'o0,      1'b0};
        vecs[2] = '{1'b0, A440, 16'o0,      1'b0, 16'o054321, 1'b1};
        vecs[3] = '{1'b1, A560, 16'o012345, 1'b0, 16'o0,      1'b0};
        vecs[4] = '{1'b0, A560, 16'o0,      1'b0, 16'o012345, 1'b1};
        vecs[5] = '{1'b0, A400, 16'o0,      1'b1, 16'o012345, 1'b1};
        vecs[6] = '{1'b1, A400, 16'o7777,   1'b1, 16'o0,      1'b0};
        vecs[7] = '{1'b0, A440, 16'o0,      1'b0, 16'o054321, 1'b1};

        // Reset state
        repeat (3) @(negedge qclk);
        chk("rst_outputs", 32'({TDMR, TSACK, TSYNC, TDIN, TDOUT, TBS7, TWTBT, DALtx,
                                busy, done, nxm, TDMGO}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;

        // Reset in the middle of a DIN wait
        @(negedge qclk);
        req = 1'b1; wr = 1'b0; addr = A400;
        @(negedge qclk);
        req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge qclk);
            seen = TDIN;
        end
        chk("rst_mid_din_reached", 32'(seen), 32'd1);
        repeat (5) @(negedge qclk);
        reset = 1'b1;
        #1;
        chk("rst_mid_bus", 32'({TDMR, TSACK, TSYNC, TDIN, TDOUT, TBS7, TWTBT, DALtx}), 32'd0);
        chk("rst_mid_busy", 32'({busy, done}), 32'd0);
        @(negedge qclk);
        reset = 1'b0;
        doneSeen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge qclk);
            doneSeen = doneSeen | done;
        end
        chk("rst_mid_no_done", 32'(doneSeen), 32'd0);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            model(vecs[i].w, vecs[i].a, vecs[i].d, mNx, mRd);
            runCheck($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d,
                     vecs[i].expNx, vecs[i].expRd, vecs[i].chkRd);
        end

        // Grant passthrough while idle, blocked while mastering
        @(negedge qclk);
        grantForce = 1'b1;
        @(negedge qclk);
        chk("grant_pass_idle", 32'(TDMGO), 32'd1);
        model(1'b0, A440, 16'd0, mNx, mRd);
        runCheck("grant_xfer", 1'b0, A440, 16'd0, mNx, mRd, 1'b1);
        @(negedge qclk);
        grantForce = 1'b0;

        // Another master holding SYNC delays the address phase
        otherSync = 1'b1;
        busyBad = 1'b0;
        seen = 1'b0;
        model(1'b0, A560, 16'd0, mNx, mRd);
        fork
            runCheck("bus_busy", 1'b0, A560, 16'd0, mNx, mRd, 1'b1);
            begin
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge qclk);
                    seen = TSACK;
                end
                for (int i = 0; i < 12; i++) begin
                    @(negedge qclk);
                    busyBad = busyBad | TSYNC | DALtx;
                end
                otherSync = 1'b0;
            end
        join
        chk("bus_busy_waitbus", 32'(seen), 32'd1);
        chk("bus_busy_no_addr", 32'(busyBad), 32'd0);

        // Randomized traffic against the reference model
        for (int k = 0; k < 24; k++) begin
            int          sel;
            logic        w;
            logic [21:0] a;
            logic [15:0] d;
            sel = $urandom_range(0, 9);
            a   = (sel == 0) ? A400 : ((sel < 5) ? A440 : A560);
            w   = 1'($urandom_range(0, 1));
            d   = 16'($urandom);
            model(w, a, d, mNx, mRd);
            runCheck($sformatf("rnd%0d", k), w, a, d, mNx, mRd, !w);
        end

        chk("protocol_exclusions", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
